// File: rtl/sekwencer_pkg.sv
// Shared types and constants for the reaction-time round controller
// (sekwencer_reakcji) and its pseudo-random delay generator.
package sekwencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REL,
        DELAY,
        LIT,
        REPORT
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] PODEJSC_MAX  = 16'hFFFF;
    localparam logic [7:0]  FALSTART_MAX = 8'hFF;

    // Right-shifting Galois step; the dropped bit folds back through the taps.
    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/generator_losowy.sv
// 16-bit Galois LFSR that supplies the random lamp-off delay and LED choice.
// It advances only when the controller asks for a new draw.
module generator_losowy
    import sekwencer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/sekwencer_reakcji.sv
// Round controller for the two-LED reaction-time tester.
// Optional false-start detection is enabled by defining SEKW_FALSTART_EN.
module sekwencer_reakcji
    import sekwencer_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          DELAY_MIN  = 16,
    parameter int          DELAY_BITS = 8,
    parameter int          TIMEOUT    = 1000,
    parameter int          TIME_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              kasuj,
    input  logic [1:0]        btn,
    output logic [1:0]        led,
    output logic              busy,
    output logic              wynik_valid,
    output logic [TIME_W-1:0] wynik_czas,
    output logic              wynik_dioda,
    output logic              wynik_trafienie,
    output logic [15:0]       liczba_podejsc,
    output logic [7:0]        falstarty
);

`ifdef SEKW_FALSTART_EN
    localparam bit FALSTART_EN = 1'b1;
`else
    localparam bit FALSTART_EN = 1'b0;
`endif

    localparam int              DLY_W    = $clog2(DELAY_MIN + (1 << DELAY_BITS));
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam longint unsigned TIME_MAX = (64'd1 << TIME_W) - 64'd1;

    state_t             state;
    logic               sel;
    logic [DLY_W-1:0]   dly_cnt;
    logic [CNT_W-1:0]   lit_cnt;
    logic [15:0]        lfsr;
    logic               step;
    logic [1:0]         sel_code;
    logic [TIME_W-1:0]  czas_sat;
    logic               unused_lfsr;

    // A new draw happens exactly when WAIT_REL hands over to DELAY.
    assign step        = (state == WAIT_REL) && !stop && (btn == 2'b00);
    assign sel_code    = sel ? 2'b10 : 2'b01;
    assign czas_sat    = (64'(lit_cnt) > TIME_MAX) ? '1 : TIME_W'(lit_cnt);
    assign unused_lfsr = ^lfsr[14:DELAY_BITS];

    generator_losowy #(
        .SEED (SEED)
    ) u_generator (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .lfsr  (lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            sel             <= 1'b0;
            dly_cnt         <= '0;
            lit_cnt         <= '0;
            led             <= 2'b00;
            busy            <= 1'b0;
            wynik_valid     <= 1'b0;
            wynik_czas      <= '0;
            wynik_dioda     <= 1'b0;
            wynik_trafienie <= 1'b0;
            liczba_podejsc  <= '0;
            falstarty       <= '0;
        end else begin
            wynik_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_REL;
                        busy  <= 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (btn == 2'b00) begin
                        dly_cnt <= DLY_W'(DELAY_MIN) + DLY_W'(lfsr[DELAY_BITS-1:0]);
                        sel     <= lfsr[15];
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (FALSTART_EN && (btn != 2'b00)) begin
                        state <= WAIT_REL;
                        if (falstarty != FALSTART_MAX) begin
                            falstarty <= falstarty + 8'd1;
                        end
                    end else if (dly_cnt == DLY_W'(1)) begin
                        // Counter value 1 is the last dark cycle, so LIT starts D cycles in.
                        state   <= LIT;
                        led     <= sel_code;
                        lit_cnt <= CNT_W'(1);
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                LIT: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        led   <= 2'b00;
                    end else if ((btn != 2'b00) || (lit_cnt == CNT_W'(TIMEOUT))) begin
                        state           <= REPORT;
                        led             <= 2'b00;
                        wynik_valid     <= 1'b1;
                        wynik_czas      <= czas_sat;
                        wynik_dioda     <= sel;
                        wynik_trafienie <= (btn == sel_code);
                        if (liczba_podejsc != PODEJSC_MAX) begin
                            liczba_podejsc <= liczba_podejsc + 16'd1;
                        end
                    end else begin
                        lit_cnt <= lit_cnt + CNT_W'(1);
                    end
                end
                REPORT: begin
                    if (stop || !start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT_REL;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    led   <= 2'b00;
                end
            endcase
            // Clearing statistics overrides any increment made on the same edge.
            if (kasuj) begin
                liczba_podejsc <= '0;
                falstarty      <= '0;
            end
        end
    end

endmodule
